upower_control_fsm: RTL

UPOWER_CONTROL_FSM -- requirements
Module: upower_control_fsm

---
 rtl/upower_ctrl_pkg.sv | 37 +++
 rtl/upower_control_fsm_if.sv | 9 +
 rtl/upower_decoder.sv | 50 +++++
 rtl/upower_control_fsm.sv | 102 ++++++++++
 4 files changed

// File: rtl/upower_ctrl_pkg.sv
// rtl/upower_ctrl_pkg.sv - uPOWER control FSM opcodes, ALU encodings, states and shared types
package upower_ctrl_pkg;

    localparam logic [5:0] OP_LD   = 6'd58;
    localparam logic [5:0] OP_STD  = 6'd62;
    localparam logic [5:0] OP_ADDI = 6'd14;
    localparam logic [5:0] OP_ANDI = 6'd28;
    localparam logic [5:0] OP_ORI  = 6'd24;
    localparam logic [5:0] OP_XO   = 6'd31;

    localparam logic [9:0] XO_ADD = 10'd266;
    localparam logic [9:0] XO_AND = 10'd28;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    typedef enum logic [1:0] {CLS_ILLEGAL, CLS_LD, CLS_STD, CLS_ALU} instr_class_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       reg1;
        logic       reg2;
        logic       mem_to_reg;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NONE = '0;

endpackage

// File: rtl/upower_control_fsm_if.sv
// rtl/upower_control_fsm_if.sv - fetch-stage instruction handshake between fetch and control FSM
interface upower_control_fsm_if;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;

    modport master (output instruction, output instr_valid, input instr_ready);
    modport slave  (input instruction, input instr_valid, output instr_ready);
endinterface

// File: rtl/upower_decoder.sv
// rtl/upower_decoder.sv - combinational uPOWER decode into instruction class and static control word
module upower_decoder
    import upower_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [9:0]   xo,
    input  logic [1:0]   ds,
    output instr_class_e cls,
    output ctrl_word_t   ctrl
);

    // Control word fields: alu_op, alu_src, reg_dst, reg1, reg2, mem_to_reg
    always_comb begin
        cls  = CLS_ILLEGAL;
        ctrl = CTRL_NONE;
        case (opcode)
            OP_LD: if (ds == 2'b00) begin
                cls  = CLS_LD;
                ctrl = '{ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            end
            OP_STD: if (ds == 2'b00) begin
                cls  = CLS_STD;
                ctrl = '{ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            end
            OP_ADDI: begin
                cls  = CLS_ALU;
                ctrl = '{ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            end
            OP_ANDI: begin
                cls  = CLS_ALU;
                ctrl = '{ALU_AND, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            end
            OP_ORI: begin
                cls  = CLS_ALU;
                ctrl = '{ALU_OR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            end
            OP_XO: begin
                if (xo == XO_ADD) begin
                    cls  = CLS_ALU;
                    ctrl = '{ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
                end else if (xo == XO_AND) begin
                    cls  = CLS_ALU;
                    ctrl = '{ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/upower_control_fsm.sv
// rtl/upower_control_fsm.sv - multi-cycle uPOWER control FSM; UPOWER_RETIRE_CNT_EN adds retire_count
module upower_control_fsm
    import upower_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    upower_control_fsm_if.slave  fetch,
    output logic [31:0]          instr_out,
    output logic [3:0]           ALU_OP,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 ALUSrc,
    output logic                 RegDst,
    output logic                 reg1,
    output logic                 reg2,
    output logic                 busy,
    output logic                 illegal
`ifdef UPOWER_RETIRE_CNT_EN
    ,
    output logic [31:0]          retire_count
`endif
);

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic         started;
    logic         accept;
    logic         in_flight;
    logic         retire;
    instr_class_e cls;
    ctrl_word_t   ctrl;

    upower_decoder u_decoder (
        .opcode (instr_out[31:26]),
        .xo     (instr_out[10:1]),
        .ds     (instr_out[1:0]),
        .cls    (cls),
        .ctrl   (ctrl)
    );

    // started keeps instr_ready low until the first edge after reset release
    assign fetch.instr_ready = started && (state == ST_IDLE);
    assign accept            = fetch.instr_valid && fetch.instr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            started   <= 1'b0;
            instr_out <= '0;
        end else begin
            started <= 1'b1;
            state   <= state_nxt;
            if (accept) begin
                instr_out <= fetch.instruction;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = (cls == CLS_ILLEGAL) ? ST_IDLE : ST_EXEC;
            ST_EXEC:   state_nxt = (cls == CLS_LD || cls == CLS_STD) ? ST_MEM : ST_WB;
            ST_MEM:    state_nxt = (cls == CLS_LD) ? ST_WB : ST_IDLE;
            ST_WB:     state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Static controls follow the decoded word only while the instruction is executing
    assign in_flight = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);
    assign ALU_OP    = in_flight ? ctrl.alu_op     : 4'b0000;
    assign ALUSrc    = in_flight && ctrl.alu_src;
    assign RegDst    = in_flight && ctrl.reg_dst;
    assign reg1      = in_flight && ctrl.reg1;
    assign reg2      = in_flight && ctrl.reg2;
    assign MemtoReg  = in_flight && ctrl.mem_to_reg;

    assign MemRead  = (cls == CLS_LD) && ((state == ST_MEM) || (state == ST_WB));
    assign MemWrite = (cls == CLS_STD) && (state == ST_MEM);
    assign RegWrite = (state == ST_WB);
    assign busy     = (state != ST_IDLE);
    assign illegal  = (state == ST_DECODE) && (cls == CLS_ILLEGAL);
    assign retire   = (state == ST_WB) || ((state == ST_MEM) && (cls == CLS_STD));

`ifdef UPOWER_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
